// File: rtl/count_capture.sv
// Trigger-driven snapshot FIFO for the free-running counter stage.
// Captures {wrap, cc, cnt} per trigger; drops are counted instead of stalling upstream.
module count_capture #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           cnt_in,
  input  logic [1:0]                 cc_in,
  input  logic                       trig,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH+2:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef logic [WIDTH+2:0] entry_t;

  entry_t           mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] prev_q;
  logic             prev_ok_q;
  logic             wrap_pend_q, wrap_pend_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic   wrap_evt, full, pop, push, drop;
  entry_t entry;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    wrap_evt    = prev_ok_q && (cnt_in < prev_q);
    full        = (level_q == LW'(DEPTH));
    out_valid   = (level_q != '0);
    pop         = out_valid && out_ready;
    push        = trig && (!full || pop);
    drop        = trig && full && !pop;
    entry       = {wrap_pend_q | wrap_evt, cc_in, cnt_in};

    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    level_d     = level_q;
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (!push && pop) level_d = level_q - LW'(1);

    // An accepted capture consumes the pending wrap; a dropped one keeps it for the next.
    wrap_pend_d = push ? 1'b0 : (wrap_pend_q | wrap_evt);

    overflow_d  = overflow_q | drop;
    drop_cnt_d  = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      prev_q      <= '0;
      prev_ok_q   <= 1'b0;
      wrap_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      prev_q      <= cnt_in;
      prev_ok_q   <= 1'b1;
      wrap_pend_q <= wrap_pend_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // NOTE: storage is not reset; level gates visibility, so stale contents never reach out_data.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry;
  end

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule
